// File: rtl/aw_wr_ctrl.sv
// Write-address stage: decodes M1 AW to S0/S1/DS, forwards it to the selected slave,
// and holds a one-hot write select for the W router until the burst's last beat.
module aw_wr_ctrl #(
   parameter int                   ID_BITS   = 4,
   parameter int                   ADDR_BITS = 32,
   parameter logic [ADDR_BITS-1:0] S0_BASE   = 32'h0000_0000,
   parameter logic [ADDR_BITS-1:0] S1_BASE   = 32'h0001_0000,
   parameter logic [3:0]           M1_TAG    = 4'b0010
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ID_BITS-1:0]   M1_AWID,
   input  logic [ADDR_BITS-1:0] M1_AWAddr,
   input  logic [3:0]           M1_AWLen,
   input  logic [2:0]           M1_AWSize,
   input  logic [1:0]           M1_AWBurst,
   input  logic                 M1_AWValid,
   output logic                 M1_AWReady,
   output logic [ID_BITS+3:0]   S_AWID,
   output logic [ADDR_BITS-1:0] S_AWAddr,
   output logic [3:0]           S_AWLen,
   output logic [2:0]           S_AWSize,
   output logic [1:0]           S_AWBurst,
   output logic                 S0_AWValid,
   output logic                 S1_AWValid,
   output logic                 DS_AWValid,
   input  logic                 S0_AWReady,
   input  logic                 S1_AWReady,
   input  logic                 DS_AWReady,
   input  logic                 M1_WValid,
   input  logic                 M1_WReady,
   input  logic                 M1_WLast,
   output logic [2:0]           wr_sel,
   output logic                 wlast_err,
   output logic [1:0]           fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid and payload stay stable until that edge, ready may change freely.
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

   state_t     state, state_nxt;
   logic       aw_hs, w_hs, slv_ready;
   logic [2:0] sel_dec, sel_q, s_valid;
   logic [3:0] beat_cnt;
   logic       aw_ready_d, err_d;
   logic [2:0] s_valid_d, wr_sel_d;

   assign aw_hs     = M1_AWValid & M1_AWReady;
   assign w_hs      = M1_WValid & M1_WReady;
   assign slv_ready = |(sel_q & {DS_AWReady, S1_AWReady, S0_AWReady});
   assign fsm_state = state;

   assign S0_AWValid = s_valid[0];
   assign S1_AWValid = s_valid[1];
   assign DS_AWValid = s_valid[2];

   always_comb begin
      sel_dec = 3'b100;
      if (M1_AWAddr[ADDR_BITS-1:ADDR_BITS-16] == S0_BASE[ADDR_BITS-1:ADDR_BITS-16])
         sel_dec = 3'b001;
      else if (M1_AWAddr[ADDR_BITS-1:ADDR_BITS-16] == S1_BASE[ADDR_BITS-1:ADDR_BITS-16])
         sel_dec = 3'b010;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (aw_hs)               state_nxt = ST_ADDR;
         ST_ADDR: if (slv_ready)           state_nxt = ST_DATA;
         ST_DATA: if (w_hs && M1_WLast)    state_nxt = ST_IDLE;
         default:                          state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, all derived from the transition being taken.
   always_comb begin
      aw_ready_d = (state_nxt == ST_IDLE);
      s_valid_d  = 3'b000;
      wr_sel_d   = 3'b000;
      if (state_nxt == ST_ADDR)
         s_valid_d = (state == ST_IDLE) ? sel_dec : sel_q;
      if (state_nxt == ST_DATA)
         wr_sel_d = sel_q;
      err_d = (state == ST_DATA) && w_hs && (M1_WLast != (beat_cnt == S_AWLen));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         M1_AWReady <= 1'b0;
         s_valid    <= 3'b000;
         wr_sel     <= 3'b000;
         wlast_err  <= 1'b0;
         sel_q      <= 3'b000;
         beat_cnt   <= 4'd0;
         S_AWID     <= '0;
         S_AWAddr   <= '0;
         S_AWLen    <= 4'd0;
         S_AWSize   <= 3'd0;
         S_AWBurst  <= 2'd0;
      end else begin
         M1_AWReady <= aw_ready_d;
         s_valid    <= s_valid_d;
         wr_sel     <= wr_sel_d;
         wlast_err  <= err_d;
         if (state == ST_IDLE && aw_hs) begin
            sel_q     <= sel_dec;
            S_AWID    <= {M1_TAG, M1_AWID};
            S_AWAddr  <= M1_AWAddr;
            S_AWLen   <= M1_AWLen;
            S_AWSize  <= M1_AWSize;
            S_AWBurst <= M1_AWBurst;
         end
         // Counter wraps naturally if the master overruns AWLen without WLast.
         if (state == ST_ADDR && slv_ready)
            beat_cnt <= 4'd0;
         else if (state == ST_DATA && w_hs)
            beat_cnt <= beat_cnt + 4'd1;
      end
   end

endmodule
